// File: rtl/div_pkg.sv
// Shared widths and FSM state encoding for the 4-bit by 3-bit sequential divider.
package div_pkg;

    localparam int DIVIDEND_W = 4;
    localparam int DIVISOR_W  = 3;
    localparam int CNT_W      = 2;

    localparam logic [CNT_W-1:0] CNT_LOAD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, compare, subtract.
module div_step
    import div_pkg::*;
(
    input  logic [DIVIDEND_W-1:0] rem_i,
    input  logic                  bit_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic [DIVIDEND_W-1:0] rem_o,
    output logic                  q_o
);

    logic [DIVIDEND_W-1:0] shifted;
    logic [DIVIDEND_W-1:0] dsr_ext;

    assign shifted = {rem_i[DIVIDEND_W-2:0], bit_i};
    assign dsr_ext = {1'b0, divisor_i};

    // A set top bit means the shifted value would exceed 4 bits, so it is always >= divisor.
    assign q_o   = rem_i[DIVIDEND_W-1] | (shifted >= dsr_ext);
    assign rem_o = q_o ? (shifted - dsr_ext) : shifted;

endmodule

// File: rtl/div_seq4b.sv
// Sequential unsigned restoring divider, 4-bit dividend / 3-bit divisor, one quotient bit per clock.
// Define DIV_ZERO_DETECT_EN to short-circuit a zero divisor straight to DONE with div_by_zero set.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, one quotient bit per cycle, MSB first
// DONE  | one-cycle result-valid pulse; a start here begins the next division
module div_seq4b
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [DIVIDEND_W-1:0] rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rout_q, rout_d;

    logic [DIVIDEND_W-1:0] step_rem;
    logic                  step_q;

`ifdef DIV_ZERO_DETECT_EN
    logic dbz_q, dbz_d;
`endif

    div_step u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rout_d  = rout_q;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            CALC: begin
                // Quotient bits shift into the vacated low end of the dividend register.
                rem_d = step_rem;
                dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = {dvd_q[DIVIDEND_W-2:0], step_q};
                    rout_d  = step_rem[DIVISOR_W-1:0];
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = CALC;
`ifdef DIV_ZERO_DETECT_EN
                    dbz_d   = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rout_d  = dividend[DIVISOR_W-1:0];
                        dbz_d   = 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rout_q  <= rout_d;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rout_q;

endmodule

// File: tb/tb_div_seq4b.sv
// Directed bench for div_seq4b: latency, back-to-back, ignored start, zero divisor, mid-op reset.
module tb_div_seq4b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [2:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [2:0] remainder;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_mis = 0;
    int last_q = 0;
    int last_r = 0;
    int lat;

    div_seq4b dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === 32'(exp)) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one start and waits (bounded) for done; leaves the bench in the done cycle.
    task automatic run_op(input logic [3:0] a, input logic [2:0] b, input int eq, input int er,
                          input int edbz, input int elat, input string tag);
        int l;
        int nbusy;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
        l = 1;
        nbusy = 0;
        while (done !== 1'b1 && l < 12) begin
            if (busy === 1'b1) nbusy++;
            if (l == 1) chk({tag, "_hold_q"}, 32'(quotient), last_q);
            step();
            l++;
        end
        chk({tag, "_latency"}, 32'(l), elat);
        chk({tag, "_busy_cycles"}, 32'(nbusy), elat - 1);
        chk({tag, "_busy_with_done"}, 32'(busy), 0);
        chk({tag, "_quotient"}, 32'(quotient), eq);
        chk({tag, "_remainder"}, 32'(remainder), er);
        chk({tag, "_dbz"}, 32'(div_by_zero), edbz);
        last_q = eq;
        last_r = er;
    endtask

    task automatic chk_idle(input string tag);
        step();
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_idle_done"}, 32'(done), 0);
        chk({tag, "_idle_q_held"}, 32'(quotient), last_q);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        chk("rst_dbz", 32'(div_by_zero), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        run_op(4'd13, 3'd3, 4, 1, 0, 5, "d13_3");
        chk_idle("d13_3");

        run_op(4'd15, 3'd1, 15, 0, 0, 5, "d15_1");
        run_op(4'd7, 3'd7, 1, 0, 0, 5, "d7_7_b2b");
        chk_idle("d7_7_b2b");

        // start pulse with 9/2 in the 2nd CALC cycle must be ignored
        dividend = 4'd2;
        divisor  = 3'd5;
        start    = 1'b1;
        step();
        start    = 1'b0;
        step();
        dividend = 4'd9;
        divisor  = 3'd2;
        start    = 1'b1;
        step();
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 3'd0;
        lat = 3;
        while (done !== 1'b1 && lat < 12) begin
            step();
            lat++;
        end
        chk("ign_latency", 32'(lat), 5);
        chk("ign_quotient", 32'(quotient), 0);
        chk("ign_remainder", 32'(remainder), 2);
        last_q = 0;
        last_r = 2;
        chk_idle("ign");

`ifdef DIV_ZERO_DETECT_EN
        run_op(4'd11, 3'd0, 15, 3, 1, 1, "d11_0");
`else
        run_op(4'd11, 3'd0, 15, 3, 0, 5, "d11_0");
`endif
        chk_idle("d11_0");

        run_op(4'd7, 3'd2, 3, 1, 0, 5, "d7_2");
        run_op(4'd8, 3'd7, 1, 1, 0, 5, "d8_7");
        run_op(4'd0, 3'd3, 0, 0, 0, 5, "d0_3");
        chk_idle("d0_3");
        run_op(4'd9, 3'd2, 4, 1, 0, 5, "d9_2");

        // reset in the 2nd CALC cycle of 14/3
        dividend = 4'd14;
        divisor  = 3'd3;
        start    = 1'b1;
        step();
        start    = 1'b0;
        step();
        chk("abort_busy_before", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_q", 32'(quotient), 0);
        chk("abort_r", 32'(remainder), 0);
        chk("abort_dbz", 32'(div_by_zero), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", 32'(done), 0);
        end
        #2;
        rst_n = 1'b1;
        last_q = 0;
        last_r = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_done", 32'(done), 0);
        end

        run_op(4'd14, 3'd3, 4, 2, 0, 5, "d14_3");
        chk_idle("d14_3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/div_seq4b.md
DIV_SEQ4B -- requirements
Module: div_seq4b

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request to begin one division; sampled on rising clk.
REQ-004 SHALL have port: dividend  input  4  unsigned dividend, the same width as the 3-bit adder sum plus carry.
REQ-005 SHALL have port: divisor  input  3  unsigned divisor.
REQ-006 SHALL have port: busy  output  1  high while iterating.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when results are valid.
REQ-008 SHALL have port: quotient  output  4  unsigned quotient.
REQ-009 SHALL have port: remainder  output  3  unsigned remainder.
REQ-010 SHALL have port: div_by_zero  output  1  divisor-was-zero flag (see Configuration).

Function
REQ-011 SHALL implement an unsigned restoring divider, one quotient bit per clk, MSB first.
REQ-012 SHALL use FSM states IDLE, CALC and DONE.
REQ-013 SHALL accept start only in IDLE or DONE, latch dividend and divisor, clear the partial remainder, load the iteration counter with 3, and move to CALC.
REQ-014 SHALL ignore start and any input changes while in CALC.
REQ-015 SHALL, each CALC cycle, form R' = {R[2:0], next dividend bit}; if R' >= divisor, R = R' - divisor and q bit = 1, else R = R' and q bit = 0.
REQ-016 SHALL, when the counter reaches 0 in CALC, move to DONE, where the 4th bit has completed.
REQ-017 SHALL follow this timing for start sampled at edge k: busy high in cycles k+1..k+4, done high only in cycle k+5, return to IDLE at k+6 unless start is sampled in DONE.
REQ-018 SHALL hold quotient and remainder stable from done until the next accepted start, and change them only at the DONE entry edge.
REQ-019 SHALL keep the internal partial remainder at 4 bits and drive remainder from its bits [2:0]; for nonzero divisors the true remainder is < 8.
REQ-020 SHALL ensure busy and done are never high together.

Reset
REQ-021 SHALL, on rst_n low at any time including mid-CALC, immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and counter=0.
REQ-022 SHALL produce no done pulse for an operation aborted by reset.

Configuration
REQ-023 SHALL compile zero-divisor detection in when macro DIV_ZERO_DETECT_EN is defined: a start with divisor=0 goes directly to DONE the next cycle, with busy never asserted, quotient=4'hF, remainder=dividend[2:0] and div_by_zero=1 for that result.
REQ-024 SHALL, with DIV_ZERO_DETECT_EN defined, clear div_by_zero at the next accepted start.
REQ-025 SHALL, without DIV_ZERO_DETECT_EN, tie div_by_zero to 0 and run divisor=0 through the normal 4-cycle CALC, giving quotient=4'hF and remainder=dividend[2:0].

Structure
REQ-026 SHALL take the state enum (IDLE/CALC/DONE) and the width constants (DIVIDEND_W=4, DIVISOR_W=3, CNT_W=2) from a shared package div_pkg.
REQ-027 SHALL place the single combinational restoring step (compare, subtract, quotient bit) in sub-module div_step, instantiated once.

Verification
REQ-028 SHALL cover: 13/3 -> done at k+5, quotient=4, remainder=1, busy high for exactly 4 cycles.
REQ-029 SHALL cover: back-to-back operations, 15/1 then start held high in DONE with 7/7 -> 15r0, then 1r0, and second busy begins the cycle after the first done.
REQ-030 SHALL cover: 2/5 -> quotient=0, remainder=2; a start pulse with 9/2 during CALC is ignored and the result is unchanged.
REQ-031 SHALL cover: 11/0 with the macro defined -> done at k+1, busy never high, quotient=15, remainder=3, div_by_zero=1; without the macro -> done at k+5, same quotient and remainder, div_by_zero=0.
REQ-032 SHALL cover: rst_n low in the 2nd CALC cycle of 14/3 -> all outputs 0 asynchronously, no done; a fresh 14/3 after release -> 4r2.
